// File: rtl/link_pkg.sv
// ----------------------------------------------------------------------------
// link_pkg
// Shared definitions for the link-training path: FSM state encodings and the
// line symbols. Used by link_training_ctrl, serial_paralelo and the benches so
// every party agrees on the same codes.
// ----------------------------------------------------------------------------
package link_pkg;

  // FSM state encodings. These are visible on the controller's state port,
  // so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_TRAIN       = 3'd1,
    ST_WAIT_ACTIVE = 3'd2,
    ST_LINKUP      = 3'd3,
    ST_RECOVER     = 3'd4
  } link_state_e;

  // Line symbols.
  localparam logic [7:0] COM       = 8'hBC;  // training / comma symbol
  localparam logic [7:0] IDLE_SYM  = 8'h7C;  // filler while the link is up
  localparam logic [7:0] RESET_SYM = 8'h00;  // driven while not transmitting

  localparam logic [3:0] RETRAIN_MAX = 4'hF;

  // Saturating increment for the retrain counter: it sticks at all-ones.
  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == RETRAIN_MAX) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/link_timer.sv
// ----------------------------------------------------------------------------
// link_timer
// Loadable up-counter with a terminal-count flag. One instance is shared by
// the TRAIN symbol count and the WAIT_ACTIVE lock timeout; the owner reloads
// it on every state change and selects the terminal value per state.
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   load_i      load load_val_i this cycle (takes priority over counting)
//   load_val_i  value loaded when load_i is high
//   en_i        count enable
//   term_i      terminal value; tc_o is high while the count equals it
//   tc_o        terminal-count flag (combinational from the count)
// ----------------------------------------------------------------------------
module link_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc_o = (count_q == term_i);

  // The counter holds once it reaches the terminal value so a caller that
  // lingers for a cycle never sees it wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && !tc_o) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/link_training_ctrl.sv
// ----------------------------------------------------------------------------
// link_training_ctrl
// Brings up a serial link: sends a burst of COM symbols, waits for the
// receiver to report lock, then passes payload bytes to the transmitter with
// one cycle of latency. Loss of lock, or a lock timeout, sends the FSM back to
// training and bumps a saturating retrain counter.
//
// tx_data / tx_valid / link_up are registered from the *next* state, so on
// any cycle they line up with the state shown on the state port.
//
// Parameters
//   NUM_TRAIN     COM symbols sent in TRAIN before waiting for lock
//   LOCK_TIMEOUT  cycles allowed in WAIT_ACTIVE before retraining
//
// Ports
//   clk_4f         sole clock, rising edge
//   reset_L        asynchronous active-low reset
//   rx_active      receiver lock indication
//   in_data        payload byte from upstream
//   in_valid       in_data valid
//   in_ready       byte accepted this cycle (high only in LINKUP)
//   tx_data        byte to the parallel-serial transmitter
//   tx_valid       tx_data valid
//   link_up        high while the state is LINKUP
//   state          current FSM state encoding
//   retrain_count  number of retrains, saturating at 15
// ----------------------------------------------------------------------------
module link_training_ctrl
  import link_pkg::*;
#(
  parameter int NUM_TRAIN    = 4,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic       clk_4f,
  input  logic       reset_L,
  input  logic       rx_active,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       link_up,
  output logic [2:0] state,
  output logic [3:0] retrain_count
);

  // The shared timer is sized for the larger of the two counts.
  localparam int TMR_MAX = (NUM_TRAIN > LOCK_TIMEOUT) ? NUM_TRAIN : LOCK_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TRAIN_TERM = TMR_W'(NUM_TRAIN - 1);
  localparam logic [TMR_W-1:0] WAIT_TERM  = TMR_W'(LOCK_TIMEOUT - 1);

  link_state_e state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        link_up_q, link_up_d;
  logic [3:0]  retrain_q, retrain_d;

  logic             timer_load;
  logic             timer_en;
  logic             timer_tc;
  logic [TMR_W-1:0] timer_term;
  logic             xfer;

  // --------------------------------------------------------------------------
  // Handshake: ready is a pure decode of the registered state.
  // --------------------------------------------------------------------------
  assign in_ready = (state_q == ST_LINKUP);
  assign xfer     = in_ready && in_valid;

  // --------------------------------------------------------------------------
  // Shared timer. Reloading on every state change means each TRAIN or
  // WAIT_ACTIVE visit starts counting from zero on its first cycle, so TRAIN
  // lasts NUM_TRAIN cycles and WAIT_ACTIVE at most LOCK_TIMEOUT cycles.
  // --------------------------------------------------------------------------
  assign timer_load = (state_d != state_q);
  assign timer_en   = (state_q == ST_TRAIN) || (state_q == ST_WAIT_ACTIVE);
  assign timer_term = (state_q == ST_TRAIN) ? TRAIN_TERM : WAIT_TERM;

  link_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk_i      (clk_4f),
    .rst_ni     (reset_L),
    .load_i     (timer_load),
    .load_val_i ('0),
    .en_i       (timer_en),
    .term_i     (timer_term),
    .tc_o       (timer_tc)
  );

  // --------------------------------------------------------------------------
  // Next-state logic and retrain accounting.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so all paths assign
    // it; a missed branch would otherwise infer a latch.
    state_d   = state_q;
    retrain_d = retrain_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_TRAIN;
      end

      ST_TRAIN: begin
        if (timer_tc) begin
          state_d = ST_WAIT_ACTIVE;
        end
      end

      ST_WAIT_ACTIVE: begin
        // Lock is tested first: a lock arriving on the timeout cycle wins
        // and is not counted as a retrain.
        if (rx_active) begin
          state_d = ST_LINKUP;
        end else if (timer_tc) begin
          state_d   = ST_TRAIN;
          retrain_d = sat_inc4(retrain_q);
        end
      end

      ST_LINKUP: begin
        if (!rx_active) begin
          state_d = ST_RECOVER;
        end
      end

      ST_RECOVER: begin
        state_d   = ST_TRAIN;
        retrain_d = sat_inc4(retrain_q);
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs, decoded from the next state. A byte accepted on the
  // last LINKUP cycle is still sent even when the FSM is leaving for RECOVER.
  // --------------------------------------------------------------------------
  always_comb begin
    tx_valid_d = 1'b1;
    tx_data_d  = COM;
    link_up_d  = (state_d == ST_LINKUP);

    if (state_d == ST_IDLE) begin
      tx_valid_d = 1'b0;
      tx_data_d  = RESET_SYM;
    end else if (xfer) begin
      tx_data_d = in_data;  // payload passes untouched, COM/IDLE_SYM included
    end else if (state_d == ST_LINKUP) begin
      tx_data_d = IDLE_SYM;
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= RESET_SYM;
      tx_valid_q <= 1'b0;
      link_up_q  <= 1'b0;
      retrain_q  <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge, independent of statement order.
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      link_up_q  <= link_up_d;
      retrain_q  <= retrain_d;
    end
  end

  assign state         = state_q;
  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign link_up       = link_up_q;
  assign retrain_count = retrain_q;

endmodule

// File: tb/tb_link_training_ctrl.sv
// ----------------------------------------------------------------------------
// tb_link_training_ctrl
// Scoreboard bench for link_training_ctrl. Each step drives inputs on the
// falling edge and pushes the outputs expected after the next rising edge;
// a monitor pops and compares them shortly after that rising edge.
// ----------------------------------------------------------------------------
module tb_link_training_ctrl;
  import link_pkg::*;

  localparam int NUM_TRAIN    = 4;
  localparam int LOCK_TIMEOUT = 64;

  logic       clk_4f = 1'b0;
  logic       reset_L;
  logic       rx_active;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       link_up;
  logic [2:0] state;
  logic [3:0] retrain_count;

  typedef struct {
    int         due;
    logic [2:0] st;
    logic [7:0] txd;
    logic       txv;
    logic       lu;
    logic       rdy;
    logic [3:0] rc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  logic       bg_v;
  logic [7:0] bg_d;
  logic       r_v;
  logic [7:0] r_d;
  logic [3:0] rc;

  // Directed payload: gap after 8'h22, then bytes equal to the line symbols.
  logic [7:0] pat_d [8] = '{8'h11, 8'h22, 8'h00, 8'h33, 8'hBC, 8'h7C, 8'h00, 8'hFF};
  logic       pat_v [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  link_training_ctrl #(
    .NUM_TRAIN    (NUM_TRAIN),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clk_4f        (clk_4f),
    .reset_L       (reset_L),
    .rx_active     (rx_active),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .link_up       (link_up),
    .state         (state),
    .retrain_count (retrain_count)
  );

  always #5 clk_4f = ~clk_4f;

  always @(posedge clk_4f) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},    state,         ST_IDLE);
    check({tag, "_tx_data"},  tx_data,       8'h00);
    check({tag, "_tx_valid"}, tx_valid,      1'b0);
    check({tag, "_link_up"},  link_up,       1'b0);
    check({tag, "_in_ready"}, in_ready,      1'b0);
    check({tag, "_retrain"},  retrain_count, 4'd0);
  endtask

  function automatic logic [3:0] rc_next(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  // Drive one cycle of inputs and queue the outputs due after the next edge.
  task automatic step(input logic rx, input logic v, input logic [7:0] d,
                      input logic [2:0] st, input logic [7:0] txd,
                      input logic lu, input logic [3:0] erc);
    exp_t e;
    @(negedge clk_4f);
    rx_active = rx;
    in_valid  = v;
    in_data   = d;
    e.due = cyc + 1;
    e.st  = st;
    e.txd = txd;
    e.txv = 1'b1;
    e.lu  = lu;
    e.rdy = (st == 3'd3);
    e.rc  = erc;
    sb.push_back(e);
  endtask

  // From the first TRAIN cycle: three more TRAIN cycles, one WAIT cycle with
  // lock present, then LINKUP.
  task automatic finish_train_lock(input logic [3:0] erc);
    repeat (NUM_TRAIN - 1) step(1'b0, bg_v, bg_d, ST_TRAIN, COM, 1'b0, erc);
    step(1'b0, bg_v, bg_d, ST_WAIT_ACTIVE, COM, 1'b0, erc);
    step(1'b1, bg_v, bg_d, ST_LINKUP, IDLE_SYM, 1'b1, erc);
  endtask

  // Monitor: compare everything that has come due.
  always @(posedge clk_4f) begin
    #2;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      check($sformatf("state@%0d", cyc),    state,         mon_e.st);
      check($sformatf("tx_data@%0d", cyc),  tx_data,       mon_e.txd);
      check($sformatf("tx_valid@%0d", cyc), tx_valid,      mon_e.txv);
      check($sformatf("link_up@%0d", cyc),  link_up,       mon_e.lu);
      check($sformatf("in_ready@%0d", cyc), in_ready,      mon_e.rdy);
      check($sformatf("retrain@%0d", cyc),  retrain_count, mon_e.rc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_L   = 1'b0;
    rx_active = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    bg_v      = 1'b0;
    bg_d      = 8'h00;

    // Reset values, immediately and while clocked.
    #1;
    check_reset("por");
    repeat (3) @(posedge clk_4f);
    #1;
    check_reset("por_hold");
    #2 reset_L = 1'b1;
    #1;
    check("rel_state",    state,    ST_IDLE);
    check("rel_tx_valid", tx_valid, 1'b0);

    // Lock held: IDLE -> 4 x TRAIN -> WAIT -> LINKUP.
    step(1'b1, 1'b0, 8'h00, ST_TRAIN, COM, 1'b0, 4'd0);
    repeat (NUM_TRAIN - 1) step(1'b1, 1'b0, 8'h00, ST_TRAIN, COM, 1'b0, 4'd0);
    step(1'b1, 1'b0, 8'h00, ST_WAIT_ACTIVE, COM, 1'b0, 4'd0);
    step(1'b1, 1'b0, 8'h00, ST_LINKUP, IDLE_SYM, 1'b1, 4'd0);

    // Payload with a gap and symbol-valued bytes, then random traffic.
    for (int i = 0; i < 8; i++)
      step(1'b1, pat_v[i], pat_d[i], ST_LINKUP, pat_v[i] ? pat_d[i] : IDLE_SYM, 1'b1, 4'd0);
    for (int i = 0; i < 16; i++) begin
      r_v = 1'($urandom_range(0, 1));
      r_d = 8'($urandom_range(0, 255));
      step(1'b1, r_v, r_d, ST_LINKUP, r_v ? r_d : IDLE_SYM, 1'b1, 4'd0);
    end
    step(1'b1, 1'b0, 8'h00, ST_LINKUP, IDLE_SYM, 1'b1, 4'd0);

    // Lock lost while 8'hA5 is accepted: A5 still goes out, then retrain.
    step(1'b0, 1'b1, 8'hA5, ST_RECOVER, 8'hA5, 1'b0, 4'd0);
    step(1'b0, 1'b1, 8'hC3, ST_TRAIN, COM, 1'b0, 4'd1);
    bg_v = 1'b1;
    bg_d = 8'hC3;
    finish_train_lock(4'd1);
    step(1'b1, 1'b1, 8'h5A, ST_LINKUP, 8'h5A, 1'b1, 4'd1);

    // Reset pulse mid-LINKUP with a byte offered: everything clears at once.
    @(posedge clk_4f);
    #3;
    in_valid = 1'b1;
    in_data  = 8'h96;
    reset_L  = 1'b0;
    #1;
    check_reset("mid_rst");
    @(posedge clk_4f);
    #1;
    check_reset("mid_rst_hold");
    #2 reset_L = 1'b1;
    #1;
    check("rel2_state",   state,   ST_IDLE);
    check("rel2_tx_data", tx_data, 8'h00);

    // Restart; the offered byte must not leak out. Lock arrives on the very
    // last WAIT cycle and must win over the timeout.
    bg_v = 1'b1;
    bg_d = 8'h96;
    step(1'b0, bg_v, bg_d, ST_TRAIN, COM, 1'b0, 4'd0);
    repeat (NUM_TRAIN - 1) step(1'b0, bg_v, bg_d, ST_TRAIN, COM, 1'b0, 4'd0);
    step(1'b0, bg_v, bg_d, ST_WAIT_ACTIVE, COM, 1'b0, 4'd0);
    repeat (LOCK_TIMEOUT - 1) step(1'b0, bg_v, bg_d, ST_WAIT_ACTIVE, COM, 1'b0, 4'd0);
    step(1'b1, bg_v, bg_d, ST_LINKUP, IDLE_SYM, 1'b1, 4'd0);

    // Lock lost with nothing offered: RECOVER sends COM.
    step(1'b0, 1'b0, 8'h00, ST_RECOVER, COM, 1'b0, 4'd0);
    rc = 4'd1;
    step(1'b0, bg_v, bg_d, ST_TRAIN, COM, 1'b0, rc);

    // No lock at all: repeated timeouts, retrain count saturates at 15.
    for (int k = 0; k < 16; k++) begin
      repeat (NUM_TRAIN - 1) step(1'b0, bg_v, bg_d, ST_TRAIN, COM, 1'b0, rc);
      step(1'b0, bg_v, bg_d, ST_WAIT_ACTIVE, COM, 1'b0, rc);
      repeat (LOCK_TIMEOUT - 1) step(1'b0, bg_v, bg_d, ST_WAIT_ACTIVE, COM, 1'b0, rc);
      rc = rc_next(rc);
      step(1'b0, bg_v, bg_d, ST_TRAIN, COM, 1'b0, rc);
    end

    // Saturated counter also holds across a RECOVER retrain.
    finish_train_lock(4'd15);
    step(1'b0, 1'b1, 8'h3C, ST_RECOVER, 8'h3C, 1'b0, 4'd15);
    step(1'b0, 1'b0, 8'h00, ST_TRAIN, COM, 1'b0, 4'd15);

    @(posedge clk_4f);
    #3;
    check("sb_drain",     sb.size(),     0);
    check("rc_saturated", retrain_count, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
